alu_seq: RTL
============

Name: alu_seq

Overview:
- Multi-cycle, parametrised-width integer ALU with valid/ready handshakes on input and output.
- Successor to the combinational lab ALU. Opcode map and zero flag are identical.
- Shifts are iterative, SHIFT_STEP bits per cycle, for smaller area. An iterative multiply is optional.
- Sits between operand issue and writeback in the multi-cycle datapath. One operation is in flight at a time, and the output is held until the consumer accepts it.

Parameters:
- WIDTH, 32, operand/result width; power of 2, 8..64.
- SHIFT_STEP, 1, maximum shift distance applied per cycle; power of 2, 1..WIDTH.
- SHAMT_W, $clog2(WIDTH), localparam (not overridable); shift amount taken from op2[SHAMT_W-1:0].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  op1/op2/alu_op valid
- in_ready  out  1  block can accept an operation this cycle
- op1  in  WIDTH  operand 1
- op2  in  WIDTH  operand 2 / shift amount
- alu_op  in  4  operation code
- out_valid  out  1  result/zero valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0)
- busy  out  1  state is SHIFT or MUL

Behaviour:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
- Reset values, entered asynchronously when rst_n=0, including mid-operation (any in-flight op is discarded):
  - state=IDLE
  - result=0, zero=0, out_valid=0, busy=0
  - in_ready=0 while rst_n=0; in_ready=1 from the first edge after release.
- Opcodes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, XOR 1101: modulo 2^WIDTH.
  - LT 0111: signed compare, result 1 or 0, zero-extended.
  - SRL 1000, SLL 1001, SRA 1010: shift by op2[SHAMT_W-1:0]; SRA is sign-filling.
  - MUL 0011: only with the optional feature.
  - All other codes: ADD.
- States: IDLE, SHIFT, MUL, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept = in_valid && in_ready. Operands and opcode are captured on accept; later input changes are ignored.
- Single-cycle ops, and shifts with shamt=0: result registered at the accept edge, go to DONE.
  - Latency 1: out_valid is high the cycle after accept.
- Shifts with shamt>0: go to SHIFT.
  - Each cycle, shift by min(remaining, SHIFT_STEP) and decrement remaining.
  - Go to DONE when remaining reaches 0.
  - Latency = ceil(shamt/SHIFT_STEP) cycles.
  - Intermediate values are internal; result stays at its previous value until DONE.
- DONE:
  - out_valid=1; result and zero are stable while !out_ready.
  - out_ready && !accept: go to IDLE, out_valid=0 next cycle.
  - out_ready && accept (simultaneous): the new op starts with no bubble. For a single-cycle op, out_valid stays 1 and result updates.
- in_valid while busy: ignored (in_ready=0); the producer must hold.
- zero is computed from the value written to result, in the same edge.
- busy=1 exactly in SHIFT/MUL.

Optional Feature:
- Macro: ALU_SEQ_MUL_EN.
- Defined:
  - alu_op 0011 enters MUL: shift-add, one op2 bit per cycle, WIDTH cycles.
  - Result = low WIDTH bits of op1*op2 (sign-agnostic).
  - op2==0 still takes WIDTH cycles.
- Undefined: 0011 is an undefined code, producing ADD in 1 cycle. The MUL state and its datapath are not synthesised.

Decomposition:
- Package alu_pkg:
  - ALUOP_* 4-bit localparams, including ALUOP_MUL=4'b0011.
  - alu_state_t enum {IDLE, SHIFT, MUL, DONE}.
  - Shared by alu_seq and its bench.
- Sub-module alu_seq_shifter:
  - Holds the iterative shift register, remaining-count and direction/arith control.
  - Interface: start, done, shamt, data in, data out.
- The FSM, handshake and logic ops stay in alu_seq.

Test Plan:
- Reset/idle: rst_n low mid-SHIFT (SHIFT_STEP=1, SLL op1=1, op2=20, reset asserted at cycle 5) → out_valid=0, result=0 and busy=0 immediately; in_ready=1 one edge after release.
- Single-cycle op: ADD op1=32'h1, op2=32'hFFFFFFFF, out_ready=1 → next cycle out_valid=1, result=0, zero=1; LT op1=32'h80000000, op2=1 → result=1.
- Iterative shift: SHIFT_STEP=1, SRA op1=32'h80000000, op2=31 → busy for 31 cycles, then result=32'hFFFFFFFF. SHIFT_STEP=4, SRL same operands, op2=31 → 8 cycles, result=1. SLL shamt=0 → latency 1.
- Backpressure: out_ready=0 for 5 cycles after XOR 32'hF0F0F0F0 ^ 32'hFFFFFFFF → result held at 32'h0F0F0F0F, in_ready=0, new in_valid ignored.
- Back-to-back: in DONE with out_ready=1 and in_valid=1 (OR 3|4) → accepted the same cycle, out_valid stays 1, result=7 next cycle. Undefined op 1110, op1=5, op2=6 → 11.
- With ALU_SEQ_MUL_EN: MUL 32'h10000 * 32'h10001 → result=32'h10000 after WIDTH=32 busy cycles. Without the macro, the same op → 32'h20001 in 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state encoding and shift-control codes for alu_seq and its bench.
package alu_pkg;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_MUL = 4'b0011;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_LT  = 4'b0111;
  localparam logic [3:0] ALUOP_SRL = 4'b1000;
  localparam logic [3:0] ALUOP_SLL = 4'b1001;
  localparam logic [3:0] ALUOP_SRA = 4'b1010;
  localparam logic [3:0] ALUOP_XOR = 4'b1101;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2,
    DONE  = 2'd3
  } alu_state_t;

  localparam logic [1:0] SH_SRL = 2'b00;
  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == ALUOP_SRL) || (op == ALUOP_SLL) || (op == ALUOP_SRA);
  endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle, counting the remaining
// distance down; done/data_out describe the step taken in the current cycle.
module alu_seq_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1,
  localparam int SHAMT_W   = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         shift_kind,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               done,
  output logic [WIDTH-1:0]   data_out
);

  localparam logic [SHAMT_W:0] STEP = (SHAMT_W + 1)'(SHIFT_STEP);

  logic               active;
  logic [1:0]         kind;
  logic [SHAMT_W-1:0] remaining;
  logic [WIDTH-1:0]   sreg;
  logic [SHAMT_W:0]   rem_ext;
  logic [SHAMT_W-1:0] amt;
  logic [SHAMT_W-1:0] rem_next;
  logic [WIDTH-1:0]   shifted;

  // amt never exceeds remaining (< WIDTH), so it always fits SHAMT_W bits
  always_comb begin
    rem_ext  = {1'b0, remaining};
    amt      = (rem_ext < STEP) ? remaining : STEP[SHAMT_W-1:0];
    rem_next = remaining - amt;
    case (kind)
      SH_SLL:  shifted = sreg << amt;
      SH_SRA:  shifted = $unsigned($signed(sreg) >>> amt);
      default: shifted = sreg >> amt;
    endcase
  end

  assign done     = active && (rem_next == '0);
  assign data_out = shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      kind      <= SH_SRL;
      remaining <= '0;
      sreg      <= '0;
    end else if (start) begin
      active    <= 1'b1;
      kind      <= shift_kind;
      remaining <= shamt;
      sreg      <= data_in;
    end else if (active) begin
      sreg      <= shifted;
      remaining <= rem_next;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes; one operation in flight.
// Optional iterative shift-add multiply is built when ALU_SEQ_MUL_EN is defined.
//
// state | meaning
// IDLE  | waiting for an operation
// SHIFT | iterative shift in progress
// MUL   | shift-add multiply in progress (ALU_SEQ_MUL_EN only)
// DONE  | result valid, held until out_ready
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       alu_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_MUL   = MUL;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]         state, state_d;
  logic               rdy_q;
  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic               start_shift;
  logic [1:0]         shift_kind;
  logic               sh_done;
  logic [WIDTH-1:0]   sh_out;
  logic [WIDTH-1:0]   calc;
  logic [WIDTH-1:0]   res_d;
  logic               res_we;

  // rdy_q keeps in_ready low through reset and until the first edge after release
  assign in_ready  = rdy_q && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_SHIFT) || (state == S_MUL);

  assign shamt       = op2[SHAMT_W-1:0];
  assign start_shift = accept && is_shift_op(alu_op) && (shamt != '0);
  assign shift_kind  = (alu_op == ALUOP_SLL) ? SH_SLL :
                       (alu_op == ALUOP_SRA) ? SH_SRA : SH_SRL;

  always_comb begin
    case (alu_op)
      ALUOP_AND: calc = op1 & op2;
      ALUOP_OR:  calc = op1 | op2;
      ALUOP_SUB: calc = op1 - op2;
      ALUOP_XOR: calc = op1 ^ op2;
      ALUOP_LT:  calc = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      // zero-distance shifts complete immediately with op1 unchanged
      ALUOP_SRL, ALUOP_SLL, ALUOP_SRA: calc = op1;
      default:   calc = op1 + op2;
    endcase
  end

  alu_seq_shifter #(
    .WIDTH      (WIDTH),
    .SHIFT_STEP (SHIFT_STEP)
  ) u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_shift),
    .shift_kind (shift_kind),
    .shamt      (shamt),
    .data_in    (op1),
    .done       (sh_done),
    .data_out   (sh_out)
  );

`ifdef ALU_SEQ_MUL_EN
  logic               start_mul;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_acc, mul_acc_d, mul_mcand, mul_mplier;
  logic [SHAMT_W:0]   mul_cnt;

  assign start_mul = accept && (alu_op == ALUOP_MUL);
  assign mul_acc_d = mul_mplier[0] ? (mul_acc + mul_mcand) : mul_acc;
  assign mul_done  = (state == S_MUL) && (mul_cnt == (SHAMT_W + 1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
    end else if (start_mul) begin
      mul_acc    <= '0;
      mul_mcand  <= op1;
      mul_mplier <= op2;
      mul_cnt    <= (SHAMT_W + 1)'(WIDTH);
    end else if (state == S_MUL) begin
      mul_acc    <= mul_acc_d;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt - 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state;
    res_we  = 1'b0;
    res_d   = calc;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (start_shift) begin
            state_d = S_SHIFT;
`ifdef ALU_SEQ_MUL_EN
          end else if (start_mul) begin
            state_d = S_MUL;
`endif
          end else begin
            state_d = S_DONE;
            res_we  = 1'b1;
          end
        end else if ((state == S_DONE) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (sh_done) begin
          state_d = S_DONE;
          res_we  = 1'b1;
          res_d   = sh_out;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        if (mul_done) begin
          state_d = S_DONE;
          res_we  = 1'b1;
          res_d   = mul_acc_d;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      rdy_q  <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      state <= state_d;
      rdy_q <= 1'b1;
      if (res_we) begin
        result <= res_d;
        zero   <= (res_d == '0);
      end
    end
  end

endmodule
